mult_seq_12_6_18_ctrl: RTL

Multi-cycle controller that computes a 12×6 → 18-bit unsigned product with a single shared instance of the existing 6×3 → 9-bit multiplier. It splits the operands into halves, steps the four 6×3 partial products through the multiplier, and accumulates them with the correct shifts. It sits between the RNS channel logic and the multiplier datapath, using a start/busy/done handshake, and replaces four parallel multiplier instances when area matters more than latency.

---
 rtl/mult_seq_12_6_18_ctrl_pkg.sv | 53 +++++
 rtl/mult_seq_12_6_18_ctrl_mul.sv | 22 ++
 rtl/mult_seq_12_6_18_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mult_seq_12_6_18_ctrl_pkg.sv
// Shared definitions for the 12x6 sequential multiplier controller:
// state encodings, step indices, partial-product shift amounts and debug view.
package mult_seq_12_6_18_ctrl_pkg;

  localparam int A_W   = 12;
  localparam int B_W   = 6;
  localparam int P_W   = 18;
  localparam int SA_W  = 6;
  localparam int SB_W  = 3;
  localparam int SP_W  = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  // Step index bit 0 selects the a half, bit 1 selects the b half.
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_HL = 2'd1;
  localparam logic [1:0] STEP_LH = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  localparam logic [4:0] SHIFT_LL = 5'd0;
  localparam logic [4:0] SHIFT_HL = 5'd6;
  localparam logic [4:0] SHIFT_LH = 5'd3;
  localparam logic [4:0] SHIFT_HH = 5'd9;

  typedef struct packed {
    state_t           state;
    logic [1:0]       step;
    logic [P_W-1:0]   acc;
  } ctrl_dbg_t;

  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      STEP_LL: sh = SHIFT_LL;
      STEP_HL: sh = SHIFT_HL;
      STEP_LH: sh = SHIFT_LH;
      default: sh = SHIFT_HH;
    endcase
    return sh;
  endfunction

  // Zero-extend a 9-bit partial product and align it for the given step.
  function automatic logic [P_W-1:0] align_pp(input logic [SP_W-1:0] pp,
                                              input logic [1:0] step);
    logic [P_W-1:0] ext;
    ext = {{(P_W-SP_W){1'b0}}, pp};
    return ext << step_shift(step);
  endfunction

endpackage

// File: rtl/mult_seq_12_6_18_ctrl_mul.sv
// Combinational 6x3 -> 9-bit unsigned multiplier built as three shifted,
// gated copies of the multiplicand summed together.
module multiplier_6_3_9_BIT
  import mult_seq_12_6_18_ctrl_pkg::*;
(
  input  logic [SA_W-1:0] a,
  input  logic [SB_W-1:0] b,
  output logic [SP_W-1:0] p
);

  logic [SP_W-1:0] row0;
  logic [SP_W-1:0] row1;
  logic [SP_W-1:0] row2;

  always_comb begin
    row0 = b[0] ? {3'b000, a}       : '0;
    row1 = b[1] ? {2'b00, a, 1'b0}  : '0;
    row2 = b[2] ? {1'b0, a, 2'b00}  : '0;
    p    = row0 + row1 + row2;
  end

endmodule

// File: rtl/mult_seq_12_6_18_ctrl.sv
// Sequential 12x6 -> 18-bit multiplier over one shared 6x3 multiplier.
// Optional macro MULT_SEQ_SKIP_ZERO_EN skips step pairs whose b half is zero.
module mult_seq_12_6_18_ctrl
  import mult_seq_12_6_18_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] result
);

  // Handshake: start is accepted on any rising edge where busy=0 (including
  // the cycle done is high); busy then stays high until the final add, and
  // done pulses for exactly one cycle alongside the freshly loaded result.

`ifdef MULT_SEQ_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  state_t          state;
  logic [1:0]      step;
  logic [P_W-1:0]  acc;
  logic [SA_W-1:0] a_lo;
  logic [SA_W-1:0] a_hi;
  logic [SB_W-1:0] b_lo;
  logic [SB_W-1:0] b_hi;

  logic [SA_W-1:0] mul_a;
  logic [SB_W-1:0] mul_b;
  logic [SP_W-1:0] mul_p;
  logic [P_W-1:0]  pp_aligned;
  logic [P_W-1:0]  sum;
  logic            b_zero;
  logic            add_en;
  logic            last_step;

  ctrl_dbg_t       dbg;

  always_comb begin
    mul_a = step[0] ? a_hi : a_lo;
    mul_b = step[1] ? b_hi : b_lo;
  end

  multiplier_6_3_9_BIT u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_comb begin
    pp_aligned = align_pp(mul_p, step);
    b_zero     = (b_lo == '0) && (b_hi == '0);
    add_en     = !(SKIP_ZERO && b_zero);
    sum        = acc + (add_en ? pp_aligned : '0);
    // With skipping, a zero b_hi ends the run after the low-b pair, or
    // immediately (at STEP_LH) when both halves are zero.
    last_step  = (step == STEP_HH) ||
                 (SKIP_ZERO && (b_hi == '0) &&
                  ((step == STEP_HL) || (step == STEP_LH)));
    dbg.state  = state;
    dbg.step   = step;
    dbg.acc    = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      step   <= STEP_LL;
      acc    <= '0;
      a_lo   <= '0;
      a_hi   <= '0;
      b_lo   <= '0;
      b_hi   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_lo  <= a[5:0];
            a_hi  <= a[11:6];
            b_lo  <= b[2:0];
            b_hi  <= b[5:3];
            acc   <= '0;
            step  <= (SKIP_ZERO && (b[2:0] == 3'd0)) ? STEP_LH : STEP_LL;
            busy  <= 1'b1;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          acc <= sum;
          if (last_step) begin
            result <= sum;
            done   <= 1'b1;
            busy   <= 1'b0;
            step   <= STEP_LL;
            state  <= ST_IDLE;
          end else begin
            step <= step + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
